// File: rtl/vga_raster_gen.sv
// rtl/vga_raster_gen.sv - free-running VGA raster scanner with sync, blanking and tick pulses
//
// Ports:
//   pixelClock    in   pixel clock, every flop rises on it
//   Reset         in   asynchronous active-high reset
//   xPosition     out  current column, 0..H_TOTAL-1
//   yPosition     out  current line, 0..V_TOTAL-1
//   displayEnable out  visible-area flag, lags the coordinates by PIPE_DELAY
//   hSync         out  horizontal sync at H_SYNC_POL when active, lags by PIPE_DELAY
//   vSync         out  vertical sync at V_SYNC_POL when active, lags by PIPE_DELAY
//   lineStart     out  one-cycle pulse while xPosition==0, never delayed
//   frameStart    out  one-cycle pulse while xPosition==0 and yPosition==0, never delayed
//
// Timing parameters must give H_TOTAL <= 2048 and V_TOTAL <= 1024 so the
// coordinates fit their 11/10-bit ports. PIPE_DELAY is 0..4.

module vga_raster_gen #(
  parameter int   H_VISIBLE  = 800,
  parameter int   H_FRONT    = 40,
  parameter int   H_SYNC     = 128,
  parameter int   H_BACK     = 88,
  parameter int   V_VISIBLE  = 600,
  parameter int   V_FRONT    = 1,
  parameter int   V_SYNC     = 4,
  parameter int   V_BACK     = 23,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1,
  parameter int   PIPE_DELAY = 0
) (
  input  logic        pixelClock,
  input  logic        Reset,
  output logic [10:0] xPosition,
  output logic [9:0]  yPosition,
  output logic        displayEnable,
  output logic        hSync,
  output logic        vSync,
  output logic        lineStart,
  output logic        frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FRONT_AT   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_AT    = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_BACK_AT    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_FRONT_AT   = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_AT    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_BACK_AT    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  // run is clear for the first edge after reset so the counters hold (0,0)
  // for one extra cycle while the aligned output registers load from (0,0).
  logic        run;
  logic [10:0] h_count;
  logic [10:0] h_next;
  logic [9:0]  v_count;
  logic [9:0]  v_next;
  phase_t      h_phase;
  phase_t      h_phase_n;
  phase_t      v_phase;
  phase_t      v_phase_n;

  // Stage 0 is aligned with the coordinates; stage PIPE_DELAY drives the pins.
  logic [PIPE_DELAY:0] de_pipe;
  logic [PIPE_DELAY:0] hs_pipe;
  logic [PIPE_DELAY:0] vs_pipe;

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (run) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_next = h_count + 11'd1;
      end
    end
  end

  // Phase transitions are keyed on the next counter value so the registered
  // sync/enable outputs line up with the coordinates they describe. When a
  // counter does not move, its value already matches the held phase.
  always_comb begin
    h_phase_n = h_phase;
    if (h_next == '0)              h_phase_n = PH_ACTIVE;
    else if (h_next == H_FRONT_AT) h_phase_n = PH_FRONT;
    else if (h_next == H_SYNC_AT)  h_phase_n = PH_SYNC;
    else if (h_next == H_BACK_AT)  h_phase_n = PH_BACK;

    v_phase_n = v_phase;
    if (v_next == '0)              v_phase_n = PH_ACTIVE;
    else if (v_next == V_FRONT_AT) v_phase_n = PH_FRONT;
    else if (v_next == V_SYNC_AT)  v_phase_n = PH_SYNC;
    else if (v_next == V_BACK_AT)  v_phase_n = PH_BACK;
  end

  always_ff @(posedge pixelClock or posedge Reset) begin
    if (Reset) begin
      run     <= 1'b0;
      h_count <= '0;
      v_count <= '0;
      h_phase <= PH_ACTIVE;
      v_phase <= PH_ACTIVE;
      de_pipe <= '0;
      hs_pipe <= {(PIPE_DELAY + 1){~H_SYNC_POL}};
      vs_pipe <= {(PIPE_DELAY + 1){~V_SYNC_POL}};
    end else begin
      run        <= 1'b1;
      h_count    <= h_next;
      v_count    <= v_next;
      h_phase    <= h_phase_n;
      v_phase    <= v_phase_n;
      de_pipe[0] <= (h_phase_n == PH_ACTIVE) && (v_phase_n == PH_ACTIVE);
      hs_pipe[0] <= (h_phase_n == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_pipe[0] <= (v_phase_n == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        de_pipe[i] <= de_pipe[i-1];
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign xPosition     = h_count;
  assign yPosition     = v_count;
  assign displayEnable = de_pipe[PIPE_DELAY];
  assign hSync         = hs_pipe[PIPE_DELAY];
  assign vSync         = vs_pipe[PIPE_DELAY];

  // Gating with run keeps the pulses to a single cycle despite the held (0,0).
  assign lineStart  = ~Reset & run & (h_count == '0);
  assign frameStart = lineStart & (v_count == '0);

endmodule
